// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory bus and decode-side handshake for instr_fetch
//   imem_req/imem_addr -> request to memory, held until imem_gnt
//   imem_gnt/imem_rvalid/imem_rdata <- grant and read response
//   inst_valid/inst_data/inst_pc -> decode, accepted by inst_ready
interface instr_fetch_if #(parameter int XLEN = 32);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;
  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready
  );
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch with a DEPTH-entry fetch buffer
//   clk            rising-edge clock
//   areset         asynchronous active-low reset
//   pc             current program counter
//   pc_load        one-cycle strobe advancing the program counter on a taken grant
//   flush          redirect; discards buffered and in-flight instructions
//   fetch_misalign sticky flag for a misaligned fetch PC, cleared by flush
//   bus            memory request/response and decode handshake (master side)
module instr_fetch #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            areset,
  input  logic [XLEN-1:0] pc,
  output logic            pc_load,
  input  logic            flush,
  output logic            fetch_misalign,
  instr_fetch_if.master   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t            state, state_n;
  logic [2*XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]     rptr, wptr;
  logic [CW-1:0]     count, count_n;
  logic [XLEN-1:0]   req_pc;
  logic              drop, grant, push, pop, aligned, go;
  assign grant   = state == REQ && bus.imem_gnt;
  assign push    = state == WAIT && bus.imem_rvalid && !drop && !flush;
  assign pop     = bus.inst_valid && bus.inst_ready && !flush;
  assign count_n = flush ? '0 : count + CW'(push) - CW'(pop);
  assign aligned = pc[1:0] == 2'b00;
  // a new request is considered only from IDLE or as the pending response lands;
  // the outstanding slot is free at that point, so credit is just the next fill level
  assign go = (state == IDLE || (state == WAIT && bus.imem_rvalid)) &&
              count_n < CW'(DEPTH) && !flush && !fetch_misalign;
  always_comb begin
    state_n = state == REQ ? (bus.imem_gnt ? WAIT : flush ? IDLE : REQ)
            : state == WAIT && !bus.imem_rvalid ? WAIT
            : go && aligned ? REQ : IDLE;
    pc_load = grant && !flush;
    bus.imem_req = state == REQ;
    bus.imem_addr = state == REQ ? pc : '0;
    bus.inst_valid = count != '0;
    {bus.inst_pc, bus.inst_data} = count != '0 ? mem[rptr] : '0;
  end
  always_ff @(posedge clk or negedge areset)
    if (!areset) begin
      state          <= IDLE;
      count          <= '0;
      rptr           <= '0;
      wptr           <= '0;
      drop           <= 1'b0;
      req_pc         <= '0;
      fetch_misalign <= 1'b0;
    end else begin
      state          <= state_n;
      count          <= count_n;
      rptr           <= flush ? '0 : rptr + AW'(pop);
      wptr           <= flush ? '0 : wptr + AW'(push);
      // a grant taken during flush still returns data, which must be thrown away
      drop           <= state == WAIT && bus.imem_rvalid ? 1'b0
                      : flush && (state == WAIT || grant) ? 1'b1 : drop;
      req_pc         <= grant ? pc : req_pc;
      fetch_misalign <= flush ? 1'b0 : fetch_misalign | (go & !aligned);
    end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= {req_pc, bus.imem_rdata};
  assert property (@(posedge clk) disable iff (!areset) !(push && count == CW'(DEPTH)));
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch with memory model and scoreboard
module tb_instr_fetch;
  logic        clk;
  logic        areset;
  logic        flush;
  logic        pc_load;
  logic        fetch_misalign;
  logic [31:0] pc = '0;
  logic        redirect;
  logic [31:0] new_pc;
  int          checks = 0;
  int          fails = 0;
  int          grants = 0;
  int          loads = 0;
  int          rvs = 0;
  int          gnt_limit = 0;
  int          ovr_at = 0;
  int          lat = 1;
  int          lat_cnt = 0;
  bit          pend = 0;
  bit          pend_dead = 0;
  bit          saw_dead = 0;
  logic [31:0] pend_addr = '0;
  logic [63:0] exp_q [$];
  int          g0, l0, r0;

  instr_fetch_if #(.XLEN(32)) bus ();

  instr_fetch #(.DEPTH(2), .XLEN(32)) dut (
    .clk(clk), .areset(areset), .pc(pc), .pc_load(pc_load),
    .flush(flush), .fetch_misalign(fetch_misalign), .bus(bus.master)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] dat(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) step(1);
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_grants(input int target, input string tag);
    for (int i = 0; i < 50 && grants < target; i++) step(1);
    chk(tag, 64'(grants), 64'(target));
  endtask

  task automatic do_flush(input logic [31:0] npc);
    flush = 1; redirect = 1; new_pc = npc;
    step(1);
    flush = 0; redirect = 0;
  endtask

  // program counter: redirect wins, otherwise advance on pc_load
  always @(posedge clk) begin
    if (redirect) pc <= new_pc;
    else if (pc_load) pc <= pc + 32'd4;
    if (pc_load) loads <= loads + 1;
  end

  // memory: same-cycle grant up to gnt_limit, response lat cycles later
  always @(negedge clk) begin
    bus.imem_rvalid = 1'b0;
    if (pend) begin
      if (lat_cnt <= 1) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = pend_dead ? 32'hDEADBEEF : dat(pend_addr);
        pend = 0;
        rvs++;
      end else lat_cnt--;
    end
    bus.imem_gnt = bus.imem_req === 1'b1 && grants < gnt_limit;
    if (bus.imem_gnt) begin
      grants++;
      pend = 1;
      pend_addr = bus.imem_addr;
      lat_cnt = lat;
      pend_dead = grants == ovr_at;
    end
  end

  // decode side: every accepted instruction is matched against the scoreboard
  always @(negedge clk) begin
    if (areset && bus.inst_valid === 1'b1 && bus.inst_data === 32'hDEADBEEF) saw_dead = 1;
    if (areset && !flush && bus.inst_valid === 1'b1 && bus.inst_ready) begin
      chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("inst_pc", 64'(bus.inst_pc), 64'(e[63:32]));
        chk("inst_data", 64'(bus.inst_data), 64'(e[31:0]));
      end
    end
  end

  initial begin
    areset = 0; flush = 0; redirect = 0; new_pc = '0; bus.inst_ready = 1;
    step(3);
    chk("rst_req", 64'(bus.imem_req), 64'd0);
    chk("rst_addr", 64'(bus.imem_addr), 64'd0);
    chk("rst_valid", 64'(bus.inst_valid), 64'd0);
    chk("rst_data", 64'(bus.inst_data), 64'd0);
    chk("rst_ipc", 64'(bus.inst_pc), 64'd0);
    chk("rst_pcload", 64'(pc_load), 64'd0);
    chk("rst_mis", 64'(fetch_misalign), 64'd0);
    areset = 1;
    step(1);
    chk("first_req", 64'(bus.imem_req), 64'd1);
    chk("first_addr", 64'(bus.imem_addr), 64'd0);
    step(2);
    chk("req_hold", 64'(bus.imem_req), 64'd1);
    chk("addr_hold", 64'(bus.imem_addr), 64'd0);
    // in-order stream of three fetches
    g0 = grants; l0 = loads;
    for (int a = 0; a < 12; a += 4) exp_q.push_back({32'(a), dat(32'(a))});
    gnt_limit = g0 + 3;
    drain("stream_drain");
    step(3);
    chk("stream_grants", 64'(grants - g0), 64'd3);
    chk("stream_loads", 64'(loads - l0), 64'd3);
    chk("stream_next_addr", 64'(bus.imem_addr), 64'hC);
    // backpressure: buffer fills after exactly DEPTH grants
    bus.inst_ready = 0;
    g0 = grants;
    for (int a = 12; a < 28; a += 4) exp_q.push_back({32'(a), dat(32'(a))});
    gnt_limit = g0 + 4;
    step(12);
    chk("full_grants", 64'(grants - g0), 64'd2);
    chk("full_req", 64'(bus.imem_req), 64'd0);
    chk("full_valid", 64'(bus.inst_valid), 64'd1);
    chk("full_head", 64'(bus.inst_pc), 64'hC);
    bus.inst_ready = 1;
    drain("resume_drain");
    chk("resume_grants", 64'(grants - g0), 64'd4);
    // flush while waiting on a response
    g0 = grants; lat = 4; ovr_at = g0 + 1; gnt_limit = g0 + 2;
    exp_q.push_back({32'h200, dat(32'h200)});
    wait_grants(g0 + 1, "wflush_grant");
    do_flush(32'h200);
    drain("wflush_drain");
    chk("wflush_grants", 64'(grants - g0), 64'd2);
    chk("wflush_no_dead", 64'(saw_dead), 64'd0);
    // flush coincident with grant
    g0 = grants; l0 = loads; lat = 2;
    gnt_limit = g0 + 1;
    do_flush(32'h300);
    step(6);
    chk("gflush_grants", 64'(grants - g0), 64'd1);
    chk("gflush_loads", 64'(loads - l0), 64'd0);
    chk("gflush_valid", 64'(bus.inst_valid), 64'd0);
    chk("gflush_req", 64'(bus.imem_req), 64'd1);
    chk("gflush_addr", 64'(bus.imem_addr), 64'h300);
    // misaligned pc
    lat = 1;
    do_flush(32'h6);
    step(3);
    chk("mis_flag", 64'(fetch_misalign), 64'd1);
    chk("mis_req", 64'(bus.imem_req), 64'd0);
    step(3);
    chk("mis_hold_flag", 64'(fetch_misalign), 64'd1);
    chk("mis_hold_req", 64'(bus.imem_req), 64'd0);
    do_flush(32'h100);
    chk("mis_clear", 64'(fetch_misalign), 64'd0);
    step(1);
    chk("mis_refetch_req", 64'(bus.imem_req), 64'd1);
    chk("mis_refetch_addr", 64'(bus.imem_addr), 64'h100);
    exp_q.push_back({32'h100, dat(32'h100)});
    gnt_limit = grants + 1;
    drain("mis_drain");
    // reset while waiting with one entry buffered
    bus.inst_ready = 0; lat = 5;
    g0 = grants; r0 = rvs;
    gnt_limit = g0 + 2;
    wait_grants(g0 + 2, "rst_wait_grants");
    chk("prerst_valid", 64'(bus.inst_valid), 64'd1);
    chk("prerst_head", 64'(bus.inst_pc), 64'h104);
    areset = 0;
    #1;
    chk("arst_req", 64'(bus.imem_req), 64'd0);
    chk("arst_addr", 64'(bus.imem_addr), 64'd0);
    chk("arst_valid", 64'(bus.inst_valid), 64'd0);
    chk("arst_data", 64'(bus.inst_data), 64'd0);
    chk("arst_ipc", 64'(bus.inst_pc), 64'd0);
    chk("arst_pcload", 64'(pc_load), 64'd0);
    chk("arst_mis", 64'(fetch_misalign), 64'd0);
    step(1);
    areset = 1;
    step(6);
    chk("stray_seen", 64'(rvs - r0), 64'd2);
    chk("stray_ignored", 64'(bus.inst_valid), 64'd0);
    chk("restart_req", 64'(bus.imem_req), 64'd1);
    chk("restart_addr", 64'(bus.imem_addr), 64'h10C);
    bus.inst_ready = 1; lat = 1;
    exp_q.push_back({32'h10C, dat(32'h10C)});
    gnt_limit = grants + 1;
    drain("restart_drain");
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL provide parameter DEPTH, 2, fetch-buffer entries; power of two, minimum 2.
REQ-002 SHALL provide parameter XLEN, 32, instruction, address and PC width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port areset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pc  input  XLEN  current PC from program counter.
REQ-006 SHALL have port pc_load  output  1  one-cycle strobe telling program counter to advance.
REQ-007 SHALL have port imem_req  output  1  instruction-memory request valid.
REQ-008 SHALL have port imem_addr  output  XLEN  request address.
REQ-009 SHALL have port imem_gnt  input  1  request accepted this cycle.
REQ-010 SHALL have port imem_rvalid  input  1  read data valid; arrives 1 or more cycles after grant.
REQ-011 SHALL have port imem_rdata  input  XLEN  read data.
REQ-012 SHALL have port flush  input  1  redirect; discard buffered and in-flight instructions.
REQ-013 SHALL have ports inst_valid output 1, inst_ready input 1, inst_data output XLEN, inst_pc output XLEN  decode-side handshake.
REQ-014 SHALL have port fetch_misalign  output  1  sticky misaligned-PC flag.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT; at most one memory request outstanding at any time.
REQ-016 Credit: enter or remain in REQ only when count + outstanding < DEPTH, pc[1:0]==0 and flush==0; otherwise IDLE.
REQ-017 In REQ, imem_req=1 and imem_addr=pc; hold both stable until imem_gnt.
REQ-018 On the imem_gnt cycle: pc_load=1 for exactly that cycle, pc captured as req_pc, go to WAIT.
REQ-019 pc_load SHALL never assert outside a grant cycle and never in a flush cycle.
REQ-020 In WAIT, on imem_rvalid: push {req_pc, imem_rdata} into FIFO unless drop=1; next state per REQ-016.
REQ-021 Response-to-next-request: REQ SHALL be re-entered the cycle after rvalid; no bubble beyond that.
REQ-022 inst_valid = (count != 0); inst_data/inst_pc = FIFO head; pop when inst_valid && inst_ready.
REQ-023 Simultaneous push and pop: count unchanged, order preserved; pointers wrap modulo DEPTH.
REQ-024 Credit guarantees no push when full; a push at full is a design error and SHALL be covered by an assertion.
REQ-025 flush: FIFO emptied next cycle (count=0, inst_valid=0); a pop in the same cycle is ignored.
REQ-026 flush in WAIT: set drop=1; the pending response is discarded; drop cleared on that rvalid.
REQ-027 flush in REQ before grant: withdraw imem_req next cycle; flush coincident with imem_gnt: the grant is taken, pc_load suppressed, drop=1.
REQ-028 While flush=1, no new request issues; fetch resumes from the new pc the cycle after flush deasserts.
REQ-029 pc[1:0]!=0 when a request would issue: no request, fetch_misalign=1, FSM held IDLE until flush, which clears the flag.
REQ-030 imem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-031 areset low SHALL immediately force: state=IDLE, count=0, pointers=0, drop=0, pc_load=0, imem_req=0, imem_addr=0, inst_valid=0, inst_data=0, inst_pc=0, fetch_misalign=0.
REQ-032 Reset mid-transaction SHALL abandon the outstanding request; a later stray rvalid SHALL be ignored per REQ-030.
REQ-033 The first request SHALL issue in the first cycle after areset deasserts, provided pc is aligned.

Verification
REQ-034 pc=0, gnt same cycle, rvalid 1 cycle later, ready=1 -> pc_load pulses once per fetch; inst_pc 0,4,8 delivered in order.
REQ-035 inst_ready=0, DEPTH=2 -> exactly 2 grants, then imem_req=0 while inst_valid=1; ready=1 resumes requests.
REQ-036 flush while in WAIT with rdata=0xDEADBEEF -> that word never appears on inst_data; next inst_pc = new pc.
REQ-037 flush coincident with imem_gnt -> pc_load stays 0; returning data dropped; FIFO empty.
REQ-038 pc=0x00000006 -> fetch_misalign=1, imem_req=0; flush with pc=0x100 -> flag clears, fetch at 0x100.
REQ-039 areset low while in WAIT -> all outputs zero immediately; stray rvalid after release ignored; fetch restarts at pc.
